bcd_add_sequencer: RTL
======================

Name: bcd_add_sequencer

Overview:
- Keypad-driven controller that sequences a 2-digit BCD addition and drives three common-anode 7-segment displays (d2 = carry digit, d1 = tens, d0 = units).
- Operands are entered one digit at a time through a valid/ready key interface.
- A single one-digit BCD adder is time-shared: low digit first, then high digit, with the carry held in a flop between the two passes.
- Sits between the keypad scanner and the display pins of the BCD adder lab datapath.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = common-anode segment patterns (segment on = 0); 0 = every display bit inverted.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- key_valid  in  1  key_code is presented this cycle.
- key_code  in  4  0-9 = digit, 0xA = '+', 0xB = '=', 0xC = clear, 0xD-0xF = invalid.
- key_ready  out  1  key is accepted on any cycle where key_valid and key_ready are both 1.
- cin  in  1  carry-in, sampled only on the cycle '=' is accepted.
- d2  out  7  carry display, bits g..a.
- d1  out  7  tens display, bits g..a.
- d0  out  7  units display, bits g..a.
- busy  out  1  high while ADD_LO or ADD_HI is active.
- err  out  1  sticky error flag.

Behaviour:
- Registers:
  - opa[7:0], opb[7:0]: two BCD digits each.
  - res[7:0], res_c.
  - cy_q: inter-digit carry.
  - cin_q.
  - state.
- States: ENTER_A, ENTER_B, ADD_LO, ADD_HI, SHOW.
- Reset:
  - state = ENTER_A; all registers = 0; err = 0; busy = 0; key_ready = 1.
  - d2 = blank (1111111); d1 = d0 = "0" (1000000).
  - Reset asserted in any state, including mid-add, takes effect at that edge. A partial result is discarded.
- key_ready = 1 in ENTER_A, ENTER_B and SHOW; 0 in ADD_LO and ADD_HI. A key held valid during the add is not consumed and is accepted in SHOW.
- Digit entry:
  - ENTER_A: opa <= {opa[3:0], digit}. ENTER_B: opb likewise.
  - A third digit shifts the oldest digit out (wrap: entering 1,2,3 gives 23).
- ENTER_A:
  - '+' -> ENTER_B, opb <= 0.
  - '=' -> err <= 1, no state change.
- ENTER_B:
  - '=' -> cin_q <= cin, ADD_LO.
  - '+' -> err <= 1, no state change.
- ADD_LO, one cycle:
  - bcd_digit_add(opa[3:0], opb[3:0], cin_q) gives res[3:0] and cy_q.
  - Digit sum s = a+b+c. If s > 9 then digit = s-10 and cout = 1; else digit = s and cout = 0.
- ADD_HI, one cycle:
  - bcd_digit_add(opa[7:4], opb[7:4], cy_q) gives res[7:4] and res_c.
  - Next state is SHOW.
- Latency: '=' accepted at edge T; result registered at edge T+2; SHOW displays from cycle T+2 onward (busy high in cycles T+1..T+2 before the edge).
- SHOW:
  - Digit -> ENTER_A with opa <= {0, digit}.
  - '+' -> chain: opa <= res, opb <= 0, ENTER_B. res_c is dropped.
  - '=' -> re-add: opa <= res, keep opb, cin_q <= cin, ADD_LO.
- Clear (0xC): in any key-accepting state -> ENTER_A, opa = opb = res = 0, res_c = 0, err = 0.
- Invalid codes 0xD-0xF: accepted, ignored, err <= 1.
- err stays set until clear or reset.
- Display, combinational from registers:
  - ENTER_A: d1/d0 = opa digits, d2 blank.
  - ENTER_B: d1/d0 = opb digits, d2 blank.
  - ADD_LO/ADD_HI: hold the previous display.
  - SHOW: d1/d0 = res digits; d2 = "1" (1111001) if res_c, else "0" (1000000).
- Segment patterns, 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Non-BCD values show blank.

Decomposition:
- Package bcd_seq_pkg:
  - Key-code constants KEY_PLUS, KEY_EQ, KEY_CLR.
  - State encoding.
  - SEG_BLANK constant and the 7-segment pattern function.
- Sub-module bcd_digit_add: combinational, 4b+4b+cin -> 4b digit + cout.
- Instantiated once in the sequencer; the sequencer muxes its operands per state.

Test Plan:
- Reset with rst_n = 0 for 2 cycles -> d2 = 1111111, d1 = d0 = 1000000, key_ready = 1, busy = 0, err = 0.
- Keys 4,7,+,5,8,= with cin = 1 -> busy high for 2 cycles. SHOW shows 106: d2 = 1111001, d1 = 1000000, d0 = 0000010.
- Keys 9,9,+,9,9,= with cin = 1 -> 199: d2 = 1111001, d1 = d0 = 0010000.
- Chain: 1,2,+,3,0,= (cin = 0) -> 42; then +,5,= (cin = 0) -> 47 with d2 = 1000000. Then '=' (cin = 0) -> 52.
- Key '3' held valid through the '=' add -> key_ready = 0 during ADD_LO/ADD_HI. Key accepted in the first SHOW cycle; display shows 03 with d2 blank.
- '=' in ENTER_A -> err = 1, display unchanged. Digits 1,2,3 -> d1/d0 show 23. Clear -> err = 0, display 00. rst_n low during ADD_HI -> ENTER_A, display 00.

Source files
------------

// File: rtl/bcd_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_seq_pkg
// Shared definitions for the BCD add sequencer:
//   - keypad codes for '+', '=' and clear
//   - FSM state encoding
//   - 7-segment patterns (bits g..a, segment on = 0) and the digit decoder
// ---------------------------------------------------------------------------
package bcd_seq_pkg;

    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_ADD_LO  = 3'd2,
        ST_ADD_HI  = 3'd3,
        ST_SHOW    = 3'd4
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// bcd_add_sequencer_if
// Key handshake and display bundle of the BCD add sequencer.
//   key_valid/key_code/key_ready : keypad valid/ready handshake
//   cin                          : carry-in, sampled when '=' is accepted
//   d2/d1/d0                     : carry/tens/units displays, bits g..a
//   busy                         : add in progress
//   err                          : sticky error flag
// master = keypad side, slave = sequencer.
// ---------------------------------------------------------------------------
interface bcd_add_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       cin;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
    logic       busy;
    logic       err;

    modport master (
        output key_valid, key_code, cin,
        input  key_ready, d2, d1, d0, busy, err
    );

    modport slave (
        input  key_valid, key_code, cin,
        output key_ready, d2, d1, d0, busy, err
    );
endinterface

// File: rtl/bcd_add_sequencer_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// One-digit BCD adder, purely combinational.
//   a_i, b_i : BCD digits
//   c_i      : carry-in
//   s_o      : BCD sum digit
//   c_o      : decimal carry-out (sum > 9)
// ---------------------------------------------------------------------------
module bcd_digit_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] sum;
    logic [4:0] sum_adj;

    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
        sum_adj = sum - 5'd10;
        if (sum > 5'd9) begin
            s_o = sum_adj[3:0];
            c_o = 1'b1;
        end else begin
            s_o = sum[3:0];
            c_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_add_sequencer
// Keypad-driven 2-digit BCD adder controller with three 7-segment displays.
// One bcd_digit_add is time-shared: low digit in ADD_LO, high digit in
// ADD_HI, with the inter-digit carry held in cy_q.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_add_sequencer_if (keys, cin, displays, flags)
// Parameter SEG_ACTIVE_LOW: 1 = common-anode patterns, 0 = all display bits
// inverted.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ENTER_A    | shifting digits into operand A, A on display
//   ENTER_B    | shifting digits into operand B, B on display
//   ADD_LO     | add low digits, keys stalled, display held
//   ADD_HI     | add high digits with carry, keys stalled
//   SHOW       | result and carry digit on display
// ---------------------------------------------------------------------------
module bcd_add_sequencer
    import bcd_seq_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_add_sequencer_if.slave   bus
);

    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'b0000000 : 7'b1111111;

    state_e     state_q, state_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [7:0] res_q, res_d;
    logic       res_c_q, res_c_d;
    logic       cy_q, cy_d;
    logic       cin_q, cin_d;
    logic       err_q, err_d;
    logic [20:0] held_q, held_d;

    logic       key_ready;
    logic       busy;
    logic       key_acc;
    logic [3:0] key;
    logic [20:0] live;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_c;
    logic [3:0] add_s;
    logic       add_co;

    assign key     = bus.key_code;
    assign key_acc = bus.key_valid & key_ready;

    // Operand mux for the shared digit adder.
    assign add_a = (state_q == ST_ADD_HI) ? opa_q[7:4] : opa_q[3:0];
    assign add_b = (state_q == ST_ADD_HI) ? opb_q[7:4] : opb_q[3:0];
    assign add_c = (state_q == ST_ADD_HI) ? cy_q       : cin_q;

    bcd_digit_add u_digit_add (
        .a_i (add_a),
        .b_i (add_b),
        .c_i (add_c),
        .s_o (add_s),
        .c_o (add_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ENTER_A;
            opa_q   <= 8'h00;
            opb_q   <= 8'h00;
            res_q   <= 8'h00;
            res_c_q <= 1'b0;
            cy_q    <= 1'b0;
            cin_q   <= 1'b0;
            err_q   <= 1'b0;
            held_q  <= {SEG_BLANK, seg7(4'd0), seg7(4'd0)};
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            res_c_q <= res_c_d;
            cy_q    <= cy_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
            held_q  <= held_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        res_c_d = res_c_q;
        cy_d    = cy_q;
        cin_d   = cin_q;
        err_d   = err_q;

        if (key_acc && key == KEY_CLR) begin
            state_d = ST_ENTER_A;
            opa_d   = 8'h00;
            opb_d   = 8'h00;
            res_d   = 8'h00;
            res_c_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_acc) begin
                        if (is_digit(key)) begin
                            opa_d = {opa_q[3:0], key};
                        end else if (key == KEY_PLUS) begin
                            opb_d   = 8'h00;
                            state_d = ST_ENTER_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ENTER_B: begin
                    if (key_acc) begin
                        if (is_digit(key)) begin
                            opb_d = {opb_q[3:0], key};
                        end else if (key == KEY_EQ) begin
                            cin_d   = bus.cin;
                            state_d = ST_ADD_LO;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ADD_LO: begin
                    res_d[3:0] = add_s;
                    cy_d       = add_co;
                    state_d    = ST_ADD_HI;
                end
                ST_ADD_HI: begin
                    res_d[7:4] = add_s;
                    res_c_d    = add_co;
                    state_d    = ST_SHOW;
                end
                ST_SHOW: begin
                    if (key_acc) begin
                        if (is_digit(key)) begin
                            opa_d   = {4'h0, key};
                            state_d = ST_ENTER_A;
                        end else if (key == KEY_PLUS) begin
                            // chaining drops the hundreds carry
                            opa_d   = res_q;
                            opb_d   = 8'h00;
                            state_d = ST_ENTER_B;
                        end else if (key == KEY_EQ) begin
                            opa_d   = res_q;
                            cin_d   = bus.cin;
                            state_d = ST_ADD_LO;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_ENTER_A;
            endcase
        end
    end

    // Outputs. During the add the last displayed value is replayed from
    // held_q, which tracks the live display in every other state.
    always_comb begin
        key_ready = 1'b1;
        busy      = 1'b0;
        live      = held_q;
        case (state_q)
            ST_ENTER_A: live = {SEG_BLANK, seg7(opa_q[7:4]), seg7(opa_q[3:0])};
            ST_ENTER_B: live = {SEG_BLANK, seg7(opb_q[7:4]), seg7(opb_q[3:0])};
            ST_ADD_LO, ST_ADD_HI: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                live      = held_q;
            end
            ST_SHOW: live = {seg7({3'b000, res_c_q}), seg7(res_q[7:4]), seg7(res_q[3:0])};
            default: live = held_q;
        endcase
        held_d = live;
    end

    assign bus.key_ready = key_ready;
    assign bus.busy      = busy;
    assign bus.err       = err_q;
    assign bus.d2        = live[20:14] ^ SEG_POL;
    assign bus.d1        = live[13:7]  ^ SEG_POL;
    assign bus.d0        = live[6:0]   ^ SEG_POL;

endmodule
